sc_stream_gen: RTL and testbench

Upstream stochastic-number stage for the bitstream aggregator. Accepts one signed 8-bit activation and one signed 8-bit weight per job, converts each to a bipolar stochastic bitstream with its own 8-bit LFSR and comparator, and XNOR-multiplies the two streams. The product stream drives the aggregator's `calc_in`, qualified by `calc_1`, for one full LFSR period of 255 cycles.

---
 rtl/sc_stream_gen.sv | 93 +++++++++
 tb/tb_sc_stream_gen.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/sc_stream_gen.sv
// Bipolar stochastic stream generator: two LFSR/comparator encoders feeding an
// XNOR multiplier, emitting one full 255-bit LFSR period per accepted job.
module sc_stream_gen #(
  parameter logic [7:0] SEED_X = 8'h01,
  parameter logic [7:0] SEED_W = 8'hB5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] x_in,
  input  logic [7:0] w_in,
  output logic       ready,
  output logic       calc_1,
  output logic       calc_in,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t     state;
  logic [7:0] lfsr_x, lfsr_w;
  logic [7:0] vx, vw;
  logic [7:0] cnt;
  logic [7:0] x_off, w_off;

  assign x_off = x_in ^ 8'h80;
  assign w_off = w_in ^ 8'h80;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      ready   <= 1'b1;
      calc_1  <= 1'b0;
      calc_in <= 1'b0;
      done    <= 1'b0;
      lfsr_x  <= SEED_X;
      lfsr_w  <= SEED_W;
      vx      <= 8'd0;
      vw      <= 8'd0;
      cnt     <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            // First bit is produced from the seeds on the accepting edge so the
            // registered output is valid in the very next cycle.
            vx      <= x_off;
            vw      <= w_off;
            calc_in <= ~((SEED_X <= x_off) ^ (SEED_W <= w_off));
            calc_1  <= 1'b1;
            lfsr_x  <= lfsr_next(SEED_X);
            lfsr_w  <= lfsr_next(SEED_W);
            cnt     <= 8'd0;
            ready   <= 1'b0;
            state   <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (cnt == 8'd254) begin
            calc_1  <= 1'b0;
            calc_in <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end else begin
            calc_in <= ~((lfsr_x <= vx) ^ (lfsr_w <= vw));
            lfsr_x  <= lfsr_next(lfsr_x);
            lfsr_w  <= lfsr_next(lfsr_w);
            cnt     <= cnt + 8'd1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          cnt   <= 8'd0;
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          ready   <= 1'b1;
          calc_1  <= 1'b0;
          calc_in <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_stream_gen.sv
// Directed bench for sc_stream_gen: stream length, ones counts, done/ready
// timing, start handshake and asynchronous reset behaviour.
module tb_sc_stream_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x_in = 8'h00;
  logic [7:0] w_in = 8'h00;
  logic       ready, calc_1, calc_in, done;

  int n_chk  = 0;
  int n_fail = 0;

  sc_stream_gen dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .w_in(w_in),
    .ready(ready), .calc_1(calc_1), .calc_in(calc_in), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_timeout"}, int'(ready === 1'b1), 1);
  endtask

  // Runs one job; index i counts negedges after the accepting edge T.
  // poke re-pulses start with different operands at i=10 and i=100.
  task automatic run_job(input string tag, input logic [7:0] x, input logic [7:0] w,
                         input int exp_ones, input bit poke);
    int ones = 0, vld = 0, first = -1, done_n = 0, done_at = -1, stray = 0;
    wait_ready(tag);
    @(negedge clk);
    start = 1'b1; x_in = x; w_in = w;
    @(posedge clk);
    for (int i = 1; i <= 257; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && (i == 10 || i == 100)) begin
        start = 1'b1; x_in = ~x; w_in = ~w;
      end
      if (calc_1) begin
        vld++;
        ones += int'(calc_in);
        if (first < 0) first = i;
      end else if (calc_in) stray++;
      if (done) begin done_n++; done_at = i; end
      if (i == 257) chk({tag, "_ready_T257"}, int'(ready), 1);
    end
    chk({tag, "_valid_len"}, vld, 255);
    chk({tag, "_first_valid"}, first, 1);
    chk({tag, "_ones"}, ones, exp_ones);
    chk({tag, "_done_pulses"}, done_n, 1);
    chk({tag, "_done_at"}, done_at, 256);
    chk({tag, "_calc_in_idle0"}, stray, 0);
  endtask

  initial begin
    // Asynchronous reset between edges.
    #3 rst = 1'b1;
    #1;
    chk("rst_ready", int'(ready), 1);
    chk("rst_calc_1", int'(calc_1), 0);
    chk("rst_calc_in", int'(calc_in), 0);
    chk("rst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_job("sat_pos", 8'h7F, 8'h7F, 255, 1'b0);
    run_job("neg_pos", 8'h80, 8'h7F, 0, 1'b0);
    run_job("neg_neg", 8'h80, 8'h80, 255, 1'b0);
    run_job("half", 8'h00, 8'h7F, 128, 1'b0);
    run_job("quarter", 8'hC0, 8'h80, 191, 1'b0);
    run_job("ignore_start", 8'h00, 8'h7F, 128, 1'b1);

    // Back-to-back with start held high across the whole first job.
    begin
      int ones2 = 0, done2 = -1;
      wait_ready("b2b");
      @(negedge clk);
      start = 1'b1; x_in = 8'h7F; w_in = 8'h7F;
      @(posedge clk);
      for (int i = 1; i <= 520; i++) begin
        @(negedge clk);
        if (i == 255) chk("b2b_valid_T255", int'(calc_1), 1);
        if (i == 256) chk("b2b_done_T256", int'(done), 1);
        if (i == 257) begin
          chk("b2b_gap_T257", int'(calc_1), 0);
          chk("b2b_ready_T257", int'(ready), 1);
        end
        if (i == 258) begin
          chk("b2b_second_T258", int'(calc_1), 1);
          start = 1'b0;
        end
        if (i >= 258 && calc_1) ones2 += int'(calc_in);
        if (i > 258 && done && done2 < 0) done2 = i;
      end
      chk("b2b_second_ones", ones2, 255);
      chk("b2b_second_done", done2, 513);
    end

    // Reset in the middle of a stream.
    begin
      int dn = 0;
      wait_ready("midrst");
      @(negedge clk);
      start = 1'b1; x_in = 8'h7F; w_in = 8'h7F;
      @(posedge clk);
      for (int i = 1; i <= 120; i++) begin
        @(negedge clk);
        start = 1'b0;
      end
      chk("midrst_pre_valid", int'(calc_1), 1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_calc_1", int'(calc_1), 0);
      chk("midrst_ready", int'(ready), 1);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        dn += int'(done);
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        dn += int'(done) + int'(calc_1);
      end
      chk("midrst_no_done", dn, 0);
      chk("midrst_idle_ready", int'(ready), 1);
    end
    run_job("post_rst", 8'h7F, 8'h7F, 255, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
